esfa_result_reporter: RTL and testbench
=======================================

# esfa_result_reporter

Downstream consumer of the ESFA benchmark top's status outputs (`isRunning`, `didRun`, `wasSuccessful`, `instructionOfError`). When a run finishes, this block sends a fixed-format ASCII verdict out of an 8N1 UART transmitter, so a host terminal can log the benchmark outcome without a debugger. It also counts run length in clock cycles. That count can be appended to the message.

## Interface
- `CLKS_PER_BIT`, default 868, is the clock cycles per UART bit (100 MHz / 115200). Legal range is 2..65535. It sets a 16-bit bit-timer.
- `clk`  in  1  is the single clock. All logic is on its rising edge.
- `reset`  in  1  is an asynchronous, active-high reset.
- `isRunning`  in  1  is high while the benchmark executes.
- `didRun`  in  1  goes high when the benchmark completes. A rising edge triggers a report.
- `wasSuccessful`  in  1  is the verdict. 1 means pass.
- `instructionOfError`  in  8  is the ID of the first failing instruction. It is only meaningful when `wasSuccessful`=0.
- `tx`  out  1  is the UART serial output. It idles high.
- `busy`  out  1  is high while a report is being captured or transmitted.
- `reportDone`  out  1  is a sticky flag: set when the last stop bit of a report ends, cleared at the next capture.

## Operation
- Edge detect: `didRun` is registered into `didRun_q`. A trigger is `didRun & !didRun_q`, evaluated only in IDLE. Triggers arriving outside IDLE are dropped, not queued.
- FSM states and transitions:
  - IDLE → LOAD on a trigger.
  - LOAD → START after 1 cycle.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if bytes remain.
  - STOP → IDLE after the last byte.
- In LOAD the block snapshots `wasSuccessful`, `instructionOfError` and the cycle counter, and clears `reportDone`. The message is built only from snapshot registers, so input changes after LOAD do not affect it.
- UART frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles. Bytes are back-to-back with no idle gap.
- Pass message: "PASS\r\n", 6 bytes (50 41 53 53 0D 0A).
- Fail message: "FAIL " + 2 uppercase hex digits (high nibble first) + "\r\n", 9 bytes.
- Hex nibble encoding: 0–9 become 0x30–0x39. A–F become 0x41–0x46.
- The byte index is a 5-bit counter. The message length is selected from the snapshot verdict.
- Cycle counter: 32 bits.
  - Cleared on a rising edge of `isRunning`.
  - Increments on every cycle where `isRunning`=1.
  - Saturates at 0xFFFFFFFF and does not wrap.
  - Holds its value while `isRunning`=0.
  - The clear has priority over the increment on the rising-edge cycle, so that cycle counts as 0.

## Timing
- Reset values: `tx`=1, `busy`=0, `reportDone`=0. State is IDLE. `didRun_q`=0, the counter is 0, and all snapshots are 0.
- Reset is asynchronous. Outputs take their reset values immediately, including when reset is asserted mid-bit or mid-message. The partial frame is abandoned. After release, no trigger occurs until `didRun` goes 0→1 again as sampled.
- Trigger at rising edge N: `busy` rises at edge N, LOAD occupies cycle N, and the start bit drives `tx` from edge N+1.
- `busy` stays high for 1 + bytes×10×`CLKS_PER_BIT` cycles. It falls on the same edge that `reportDone` rises.
- If `didRun` is already high when reset releases, the first sampled cycle counts as a rising edge (`didRun_q`=0), so one report is sent.

## Configuration
- `ESFA_REPORT_CYCLES_EN` defined: both messages insert " C=" + 8 uppercase hex digits of the snapshot cycle count (MSB nibble first) before "\r\n".
  - Pass message becomes 17 bytes.
  - Fail message becomes 20 bytes.
- `ESFA_REPORT_CYCLES_EN` undefined: the counter and its snapshot are not compiled. Messages are exactly as described under Operation.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and a bench UART monitor.

1. Reset held, then released, with `didRun`=0 for 50 cycles → `tx`=1, `busy`=0 and `reportDone`=0 throughout.
2. `wasSuccessful`=1, pulse `didRun` 0→1 and hold → bytes 50 41 53 53 0D 0A. `busy` is high for exactly 241 cycles, then `reportDone`=1.
3. `wasSuccessful`=0 and `instructionOfError`=0x3C, then trigger → bytes 46 41 49 4C 20 33 43 0D 0A. Changing `instructionOfError` to 0xFF during transmission has no effect.
4. `didRun` toggles 1→0→1 during transmission → no second report. A new rise after `busy` falls → full second report, and `reportDone` is low from its LOAD cycle until that report ends.
5. Assert reset mid data bit of byte 3 → `tx`=1 and `busy`=0 immediately, with no further bytes sent. After release with `didRun` held at 1 → exactly one new report.
6. With `ESFA_REPORT_CYCLES_EN` defined: `isRunning` high for 301 cycles, then a pass trigger → "PASS C=0000012C\r\n". A forced counter value of 0xFFFFFFFE with 5 more running cycles reports "FFFFFFFF".

Source files
------------

// File: rtl/esfa_result_reporter.sv
// Sends an ASCII PASS/FAIL verdict over an 8N1 UART each time didRun rises.
// Define ESFA_REPORT_CYCLES_EN to append " C=" plus the 8-hex-digit run length.
module esfa_result_reporter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       isRunning,
  input  logic       didRun,
  input  logic       wasSuccessful,
  input  logic [7:0] instructionOfError,
  output logic       tx,
  output logic       busy,
  output logic       reportDone,
  output logic [2:0] dbgState
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  PASS_PRE = 5'd4;
  localparam logic [4:0]  FAIL_PRE = 5'd7;
`ifdef ESFA_REPORT_CYCLES_EN
  localparam logic [4:0]  TAIL_LEN = 5'd13;
`else
  localparam logic [4:0]  TAIL_LEN = 5'd2;
`endif

  state_t      state, stateNext;
  logic        didRunQ;
  logic        trigger;
  logic [15:0] bitTimer;
  logic        bitDone;
  logic [2:0]  bitIdx;
  logic [4:0]  byteIdx;
  logic        lastByte;
  logic        snapPass;
  logic [7:0]  snapErr;
  logic [4:0]  prefixLen;
  logic [4:0]  msgLen;
  logic [4:0]  tailIdx;
  logic [7:0]  curByte;

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    hexChar = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign trigger  = didRun & ~didRunQ;
  assign bitDone  = (bitTimer == BIT_LAST);
  assign lastByte = (byteIdx == msgLen - 5'd1);

  // Run-length counter; the rising-edge cycle itself counts as zero.
`ifdef ESFA_REPORT_CYCLES_EN
  logic        isRunningQ;
  logic [31:0] cycleCount;
  logic [31:0] snapCycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isRunningQ <= 1'b0;
      cycleCount <= 32'd0;
      snapCycles <= 32'd0;
    end else begin
      isRunningQ <= isRunning;
      if (isRunning && !isRunningQ)
        cycleCount <= 32'd0;
      else if (isRunning && cycleCount != 32'hFFFF_FFFF)
        cycleCount <= cycleCount + 32'd1;
      if (state == LOAD)
        snapCycles <= cycleCount;
    end
  end
`else
  logic unusedIsRunning;
  assign unusedIsRunning = isRunning;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (trigger) stateNext = LOAD;
      LOAD:    stateNext = START;
      START:   if (bitDone) stateNext = DATA;
      DATA:    if (bitDone && bitIdx == 3'd7) stateNext = STOP;
      STOP:    if (bitDone) stateNext = lastByte ? IDLE : START;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    dbgState = state;
    tx       = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = curByte[bitIdx];
      default: tx = 1'b1;
    endcase
  end

  // Bit/byte sequencing and the LOAD-time snapshot that the message is built from.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      didRunQ    <= 1'b0;
      bitTimer   <= 16'd0;
      bitIdx     <= 3'd0;
      byteIdx    <= 5'd0;
      snapPass   <= 1'b0;
      snapErr    <= 8'd0;
      reportDone <= 1'b0;
    end else begin
      didRunQ <= didRun;

      if (state == IDLE && trigger)
        reportDone <= 1'b0;
      else if (state == STOP && bitDone && lastByte)
        reportDone <= 1'b1;

      if (state == LOAD) begin
        snapPass <= wasSuccessful;
        snapErr  <= instructionOfError;
        byteIdx  <= 5'd0;
      end else if (state == STOP && bitDone) begin
        byteIdx <= byteIdx + 5'd1;
      end

      if ((state == START || state == DATA || state == STOP) && !bitDone)
        bitTimer <= bitTimer + 16'd1;
      else
        bitTimer <= 16'd0;

      if (state != DATA)
        bitIdx <= 3'd0;
      else if (bitDone)
        bitIdx <= bitIdx + 3'd1;
    end
  end

  // Message byte for the current index: verdict prefix, optional cycle field, CR LF.
  always_comb begin
    prefixLen = snapPass ? PASS_PRE : FAIL_PRE;
    msgLen    = prefixLen + TAIL_LEN;
    tailIdx   = byteIdx - prefixLen;
    curByte   = 8'h0A;
    if (byteIdx < prefixLen) begin
      if (snapPass) begin
        case (byteIdx[1:0])
          2'd0:    curByte = 8'h50;
          2'd1:    curByte = 8'h41;
          default: curByte = 8'h53;
        endcase
      end else begin
        case (byteIdx[2:0])
          3'd0:    curByte = 8'h46;
          3'd1:    curByte = 8'h41;
          3'd2:    curByte = 8'h49;
          3'd3:    curByte = 8'h4C;
          3'd4:    curByte = 8'h20;
          3'd5:    curByte = hexChar(snapErr[7:4]);
          default: curByte = hexChar(snapErr[3:0]);
        endcase
      end
    end else begin
`ifdef ESFA_REPORT_CYCLES_EN
      case (tailIdx)
        5'd0:    curByte = 8'h20;
        5'd1:    curByte = 8'h43;
        5'd2:    curByte = 8'h3D;
        5'd3:    curByte = hexChar(snapCycles[31:28]);
        5'd4:    curByte = hexChar(snapCycles[27:24]);
        5'd5:    curByte = hexChar(snapCycles[23:20]);
        5'd6:    curByte = hexChar(snapCycles[19:16]);
        5'd7:    curByte = hexChar(snapCycles[15:12]);
        5'd8:    curByte = hexChar(snapCycles[11:8]);
        5'd9:    curByte = hexChar(snapCycles[7:4]);
        5'd10:   curByte = hexChar(snapCycles[3:0]);
        5'd11:   curByte = 8'h0D;
        default: curByte = 8'h0A;
      endcase
`else
      curByte = (tailIdx == 5'd0) ? 8'h0D : 8'h0A;
`endif
    end
  end

endmodule

// File: tb/tb_esfa_result_reporter.sv
// Bench for esfa_result_reporter: UART monitor feeding a byte scoreboard, table of report
// scenarios, plus hand-written reset-abort and (with ESFA_REPORT_CYCLES_EN) cycle-count sequences.
`timescale 1ns/1ps
module tb_esfa_result_reporter;

  localparam int CPB     = 4;
  localparam int BYTE_CY = CPB * 10;
`ifdef ESFA_REPORT_CYCLES_EN
  localparam int PASS_LEN = 17;
  localparam int FAIL_LEN = 20;
`else
  localparam int PASS_LEN = 6;
  localparam int FAIL_LEN = 9;
`endif

  typedef struct {
    logic       succ;
    logic [7:0] err;
    logic       scramble;
    logic       retrig;
    int         expBusy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       isRunning = 1'b0;
  logic       didRun = 1'b0;
  logic       wasSuccessful = 1'b0;
  logic [7:0] instructionOfError = 8'h00;
  logic       tx;
  logic       busy;
  logic       reportDone;
  logic [2:0] dbgState;

  logic [7:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  esfa_result_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .isRunning(isRunning),
    .didRun(didRun),
    .wasSuccessful(wasSuccessful),
    .instructionOfError(instructionOfError),
    .tx(tx),
    .busy(busy),
    .reportDone(reportDone),
    .dbgState(dbgState)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'h0A;
  endfunction

  // Expected-byte model: pushes the whole report for the given verdict/cycle count.
  task automatic push_report(input logic succ, input logic [7:0] err, input logic [31:0] cyc);
    if (succ) begin
      exp_q.push_back(8'h50); exp_q.push_back(8'h41);
      exp_q.push_back(8'h53); exp_q.push_back(8'h53);
    end else begin
      exp_q.push_back(8'h46); exp_q.push_back(8'h41);
      exp_q.push_back(8'h49); exp_q.push_back(8'h4C);
      exp_q.push_back(8'h20);
      exp_q.push_back(hex_ascii(err[7:4]));
      exp_q.push_back(hex_ascii(err[3:0]));
    end
`ifdef ESFA_REPORT_CYCLES_EN
    exp_q.push_back(8'h20); exp_q.push_back(8'h43); exp_q.push_back(8'h3D);
    for (int i = 7; i >= 0; i--) exp_q.push_back(hex_ascii(cyc[i*4 +: 4]));
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // UART monitor: sampled on the falling edge, mid-bit, aborts on reset.
  logic       monActive = 1'b0;
  int         monCnt = 0;
  logic [7:0] monByte = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      monActive = 1'b0;
    end else if (!monActive) begin
      if (tx == 1'b0) begin
        monActive = 1'b1;
        monCnt = 0;
      end
    end else begin
      monCnt++;
      for (int i = 0; i < 8; i++)
        if (monCnt == 4 * (i + 1) + 2) monByte[i] = tx;
      if (monCnt == 38) begin
        monActive = 1'b0;
        check("stop_bit", {31'd0, tx}, 32'd1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_unexpected: got byte %02h, required no byte", monByte);
        end else begin
          check("rx_byte", {24'd0, monByte}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Counts busy cycles from LOAD onward, optionally disturbing inputs mid-report.
  task automatic measure_busy(input int expBusy, input logic scramble, input logic retrig);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      cnt++;
      if (scramble && cnt == 20) begin
        instructionOfError = 8'hFF;
        wasSuccessful = ~wasSuccessful;
      end
      if (retrig && cnt == 60) didRun = 1'b0;
      if (retrig && cnt == 64) didRun = 1'b1;
      @(negedge clk);
    end
    check("busy_cycles", cnt, expBusy);
    check("report_done", {31'd0, reportDone}, 32'd1);
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_load();
    check("load_busy", {31'd0, busy}, 32'd1);
    check("load_done_clear", {31'd0, reportDone}, 32'd0);
    check("load_tx_idle", {31'd0, tx}, 32'd1);
  endtask

  task automatic run_report(input logic succ, input logic [7:0] err, input logic scramble,
                            input logic retrig, input int expBusy, input logic [31:0] cyc);
    wasSuccessful = succ;
    instructionOfError = err;
    didRun = 1'b0;
    @(negedge clk);
    push_report(succ, err, cyc);
    didRun = 1'b1;
    @(negedge clk);
    check_load();
    measure_busy(expBusy, scramble, retrig);
  endtask

  initial begin
    vec_t vecs[6];
    int   bad;

    vecs[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 1 + PASS_LEN * BYTE_CY};
    vecs[1] = '{1'b0, 8'h3C, 1'b1, 1'b0, 1 + FAIL_LEN * BYTE_CY};
    vecs[2] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1 + FAIL_LEN * BYTE_CY};
    vecs[3] = '{1'b1, 8'h77, 1'b1, 1'b1, 1 + PASS_LEN * BYTE_CY};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1 + FAIL_LEN * BYTE_CY};
    vecs[5] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1 + FAIL_LEN * BYTE_CY};

    // Reset held, then quiet idle with didRun low
    repeat (5) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, reportDone}, 32'd0);
    check("rst_state", {29'd0, dbgState}, 32'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || reportDone !== 1'b0) bad++;
    end
    check("idle_quiet_cycles_bad", bad, 32'd0);

    // Table of full reports
    for (int v = 0; v < 6; v++)
      run_report(vecs[v].succ, vecs[v].err, vecs[v].scramble, vecs[v].retrig,
                 vecs[v].expBusy, 32'd0);

    // Reset in the middle of a data bit of byte 3, then re-trigger from held didRun
    wasSuccessful = 1'b0;
    instructionOfError = 8'h5A;
    didRun = 1'b0;
    @(negedge clk);
    push_report(1'b0, 8'h5A, 32'd0);
    didRun = 1'b1;
    repeat (1 + 3 * BYTE_CY + 10) @(negedge clk);
    check("pre_abort_rx_count", exp_q.size(), FAIL_LEN - 3);
    #2 reset = 1'b1;
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, reportDone}, 32'd0);
    exp_q.delete();
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("abort_hold_bad", bad, 32'd0);
    wasSuccessful = 1'b1;
    push_report(1'b1, 8'h00, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_load();
    measure_busy(1 + PASS_LEN * BYTE_CY, 1'b0, 1'b0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    check("post_reset_single_report", bad, 32'd0);

`ifdef ESFA_REPORT_CYCLES_EN
    // 301 running cycles: the first clears, 300 increments follow
    isRunning = 1'b1;
    repeat (301) @(negedge clk);
    isRunning = 1'b0;
    repeat (3) @(negedge clk);
    run_report(1'b1, 8'h00, 1'b0, 1'b0, 1 + PASS_LEN * BYTE_CY, 32'h0000_012C);

    // Saturation from a forced near-maximum count
    isRunning = 1'b1;
    repeat (3) @(negedge clk);
    force dut.cycleCount = 32'hFFFF_FFFE;
    #1;
    release dut.cycleCount;
    repeat (5) @(negedge clk);
    isRunning = 1'b0;
    run_report(1'b1, 8'h00, 1'b0, 1'b0, 1 + PASS_LEN * BYTE_CY, 32'hFFFF_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
